// File: rtl/fpgc_bus_pkg.sv
// Shared definitions for the system memory bus and its arbiters.
// Widths, arbiter state encoding and master identifiers.
package fpgc_bus_pkg;

    localparam int BUS_ADDR_W = 27;
    localparam int BUS_DATA_W = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DMA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner select, round-robin or fixed priority.
// Purely combinational; also used by the VRAM port arbiter.
module rr_pick2
    import fpgc_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic       grant
);

    // On a tie the master that did not go last wins unless master 0 is fixed.
    always_comb begin
        grant = MST_CPU;
        unique case (req)
            2'b01:   grant = MST_CPU;
            2'b10:   grant = MST_DMA;
            2'b11:   grant = fixed_prio ? MST_CPU : ~last_grant;
            default: grant = MST_CPU;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master memory bus arbiter: CPU (master 0) and DMA (master 1).
// Optional watchdog abort is enabled with `define BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import fpgc_bus_pkg::*;
#(
    parameter int ADDR_W         = BUS_ADDR_W,
    parameter int DATA_W         = BUS_DATA_W,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_data,
    input  logic              m0_we,
    input  logic              m0_start,
    output logic [DATA_W-1:0] m0_q,
    output logic              m0_done,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_data,
    input  logic              m1_we,
    input  logic              m1_start,
    output logic [DATA_W-1:0] m1_q,
    output logic              m1_done,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_we,
    output logic              bus_start,
    input  logic [DATA_W-1:0] bus_q,
    input  logic              bus_done,
    output logic              owner,
    output logic              bus_err
);

    logic [ADDR_W-1:0] in_addr [2];
    logic [DATA_W-1:0] in_data [2];
    logic [1:0]        in_we;
    logic [1:0]        in_start;

    assign in_addr[0] = m0_addr;
    assign in_addr[1] = m1_addr;
    assign in_data[0] = m0_data;
    assign in_data[1] = m1_data;
    assign in_we      = {m1_we, m0_we};
    assign in_start   = {m1_start, m0_start};

    logic [1:0]        pend_q;
    logic [ADDR_W-1:0] hold_addr_q [2];
    logic [DATA_W-1:0] hold_data_q [2];
    logic [1:0]        hold_we_q;
    logic [1:0]        accept;
    logic [1:0]        req;
    logic [1:0]        clr;

    arb_state_e        state_q, state_d;
    logic              last_q;
    logic              owner_q;
    logic              win;
    logic              issue, finish, abort, tmo;
    logic              fixed_prio;

    logic              bus_start_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_data_q;
    logic              bus_we_q;
    logic [1:0]        done_q;
    logic [DATA_W-1:0] q_q [2];

    // A start is only taken while that master has nothing outstanding.
    assign accept     = in_start & ~pend_q;
    assign req        = pend_q | accept;
    assign fixed_prio = (FIXED_PRIO != 0);

    rr_pick2 u_pick (
        .req        (req),
        .last_grant (last_q),
        .fixed_prio (fixed_prio),
        .grant      (win)
    );

    // Per-master request latch; cleared when that master's transaction ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q    <= '0;
            hold_we_q <= '0;
            for (int m = 0; m < 2; m++) begin
                hold_addr_q[m] <= '0;
                hold_data_q[m] <= '0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (accept[m]) begin
                    pend_q[m]      <= 1'b1;
                    hold_addr_q[m] <= in_addr[m];
                    hold_data_q[m] <= in_data[m];
                    hold_we_q[m]   <= in_we[m];
                end else if (clr[m]) begin
                    pend_q[m] <= 1'b0;
                end
            end
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ARB_IDLE;
        else       state_q <= state_d;
    end

    // Next state: one transaction in flight at a time.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (|req) state_d = ARB_BUSY;
            ARB_BUSY: if (bus_done || tmo) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Decode issue/completion events; bus_done outside BUSY is dropped.
    always_comb begin
        issue  = (state_q == ARB_IDLE) && (|req);
        finish = (state_q == ARB_BUSY) && bus_done;
        abort  = (state_q == ARB_BUSY) && !bus_done && tmo;
        clr    = '0;
        if (finish || abort) clr[owner_q] = 1'b1;
    end

    // Registered bus and master-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_start_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            bus_we_q    <= 1'b0;
            owner_q     <= MST_CPU;
            last_q      <= MST_DMA;
            done_q      <= '0;
            q_q[0]      <= '0;
            q_q[1]      <= '0;
        end else begin
            bus_start_q <= issue;
            done_q      <= '0;
            if (issue) begin
                // Winner may be a same-cycle start not yet in its latch.
                bus_addr_q <= pend_q[win] ? hold_addr_q[win] : in_addr[win];
                bus_data_q <= pend_q[win] ? hold_data_q[win] : in_data[win];
                bus_we_q   <= pend_q[win] ? hold_we_q[win] : in_we[win];
                owner_q    <= win;
            end
            if (finish || abort) begin
                done_q[owner_q] <= 1'b1;
                q_q[owner_q]    <= finish ? bus_q : '0;
                last_q          <= owner_q;
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Cycles spent in BUSY; zero on the first BUSY cycle.
    always_ff @(posedge clk) begin
        if (reset || state_q != ARB_BUSY) cnt_q <= '0;
        else                              cnt_q <= cnt_q + 1'b1;
    end

    assign tmo = (state_q == ARB_BUSY) && (cnt_q == CNT_LAST);

    // Sticky error once any transaction has been aborted.
    always_ff @(posedge clk) begin
        if (reset)      err_q <= 1'b0;
        else if (abort) err_q <= 1'b1;
    end

    assign bus_err = err_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo            = 1'b0;
    assign bus_err        = 1'b0;
`endif

    assign bus_start = bus_start_q;
    assign bus_addr  = bus_addr_q;
    assign bus_data  = bus_data_q;
    assign bus_we    = bus_we_q;
    assign owner     = owner_q;
    assign m0_done   = done_q[0];
    assign m1_done   = done_q[1];
    assign m0_q      = q_q[0];
    assign m1_q      = q_q[1];

endmodule
